branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 The block SHALL have parameter IDX_W, default 4, meaning BTB index width (2^IDX_W entries, direct-mapped).
REQ-002 The block SHALL have parameter CTR_INIT, default 2'b01, meaning counter value loaded into every entry at reset (weakly not-taken).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port pc, input, 16 bits: current fetch PC.
REQ-006 The block SHALL have port ex_valid, input, 1 bit: an instruction is resolved in EX this cycle.
REQ-007 The block SHALL have port ex_isBranch, input, 1 bit: the EX instruction is a branch or jump.
REQ-008 The block SHALL have port ex_taken, input, 1 bit: the actual branch outcome.
REQ-009 The block SHALL have port ex_pc, input, 16 bits: the PC of the EX instruction.
REQ-010 The block SHALL have port ex_target, input, 16 bits: the actual taken target.
REQ-011 The block SHALL have port ex_predPC, input, 16 bits: the prePC issued for this instruction at fetch, carried down the pipeline.
REQ-012 The block SHALL have port prePC, output, 16 bits: the predicted next fetch PC.
REQ-013 The block SHALL have port predTaken, output, 1 bit: the fetch prediction is taken.
REQ-014 The block SHALL have port error, output, 1 bit: misprediction detected in EX.
REQ-015 The block SHALL have port newPC, output, 16 bits: the correct redirect PC.
REQ-016 The block SHALL have port missCount, output, 16 bits: saturating mispredict counter.

Function
REQ-017 Each entry SHALL hold: valid (1), tag pc[15:IDX_W] (16-IDX_W bits), target (16), ctr (2).
REQ-018 Lookup SHALL be combinational: hit = valid[idx] && tag[idx]==pc[15:IDX_W], with idx = pc[IDX_W-1:0].
REQ-019 predTaken SHALL be hit && ctr[1]; prePC SHALL be target[idx] when predTaken, else pc+1 (mod 2^16, 16'hFFFF+1 = 16'h0000).
REQ-020 actual_next SHALL be ex_target when (ex_isBranch && ex_taken), else ex_pc+1 (mod 2^16).
REQ-021 error SHALL be combinational: ex_valid && (ex_predPC != actual_next); newPC SHALL equal actual_next at all times.
REQ-022 Update, applied at the clock edge, SHALL require ex_valid=1, and SHALL use an index/tag taken from ex_pc.
REQ-023 Branch, tag hit: ctr SHALL saturating-increment on taken (max 2'b11) and saturating-decrement on not-taken (min 2'b00); target SHALL be overwritten with ex_target when taken.
REQ-024 Branch, tag miss, taken: the entry SHALL be allocated (replacing any occupant) with valid=1, tag, target=ex_target, ctr=2'b10.
REQ-025 Branch, tag miss, not-taken: the table SHALL be left unchanged.
REQ-026 Non-branch with tag hit (alias): valid[idx] SHALL be cleared; non-branch with tag miss: no change.
REQ-027 When fetch and update hit the same index in the same cycle, lookup SHALL return the pre-update contents (no bypass); the new value becomes visible the next cycle.
REQ-028 missCount SHALL increment by 1 at each edge where error=1 and SHALL saturate at 16'hFFFF.
REQ-029 ex_valid=0 SHALL cause no table or counter change, regardless of the other ex_* inputs; the pipeline deasserts ex_valid during stalls and flushes so that no instruction is updated twice.

Reset
REQ-030 Asserting rst=0 SHALL, asynchronously and regardless of clk, clear all valid bits, set every ctr to CTR_INIT, and clear missCount to 0; targets and tags need not be cleared.
REQ-031 While rst=0, the outputs SHALL be prePC=pc+1, predTaken=0 and missCount=0; error/newPC SHALL remain combinational from the EX inputs.
REQ-032 Reset asserted in the middle of an update cycle SHALL win: no entry written at that edge survives.

Verification
REQ-033 The bench SHALL cover: after reset, pc=16'h0010 -> prePC=16'h0011, predTaken=0.
REQ-034 The bench SHALL cover: taken branch ex_pc=16'h0010, ex_target=16'h0040, ex_predPC=16'h0011 -> error=1, newPC=16'h0040; next cycle pc=16'h0010 -> predTaken=1, prePC=16'h0040, missCount=1.
REQ-035 The bench SHALL cover: same branch resolved not-taken twice (ex_predPC=16'h0040 each time) -> error=1 both times with newPC=16'h0011; ctr 10->01->00; pc=16'h0010 then gives predTaken=0.
REQ-036 The bench SHALL cover: an entry for 16'h0010, then a taken branch at 16'h0110 (same idx, new tag) -> entry replaced; pc=16'h0010 misses (prePC=16'h0011), pc=16'h0110 hits.
REQ-037 The bench SHALL cover: a non-branch at ex_pc=16'h0110 with entry valid -> entry invalidated; with ex_predPC=16'h0111 -> error=0.
REQ-038 The bench SHALL cover: 65536+ consecutive mispredicts -> missCount holds 16'hFFFF; then rst pulsed low mid-cycle -> missCount=0 and all lookups miss immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational fetch lookup and EX mispredict detect;
// table and missCount update on the clock edge after EX resolve, with no backpressure.
module branch_predictor #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pc,
  input  logic        ex_valid,
  input  logic        ex_isBranch,
  input  logic        ex_taken,
  input  logic [15:0] ex_pc,
  input  logic [15:0] ex_target,
  input  logic [15:0] ex_predPC,
  output logic [15:0] prePC,
  output logic        predTaken,
  output logic        error,
  output logic [15:0] newPC,
  output logic [15:0] missCount
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 16 - IDX_W;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag    [ENTRIES];
  logic [15:0]        target [ENTRIES];
  logic [1:0]         ctr    [ENTRIES];

  logic [IDX_W-1:0] idx, ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             hit, ex_hit;
  logic [15:0]      actual_next;

  assign idx    = pc[IDX_W-1:0];
  assign ex_idx = ex_pc[IDX_W-1:0];
  assign ex_tag = ex_pc[15:IDX_W];

  // Fetch sees the pre-update table contents; there is deliberately no bypass from EX.
  assign hit       = valid[idx] && (tag[idx] == pc[15:IDX_W]);
  assign predTaken = rst && hit && ctr[idx][1];
  assign prePC     = predTaken ? target[idx] : pc + 16'd1;

  assign ex_hit      = valid[ex_idx] && (tag[ex_idx] == ex_tag);
  assign actual_next = (ex_isBranch && ex_taken) ? ex_target : ex_pc + 16'd1;
  assign error       = ex_valid && (ex_predPC != actual_next);
  assign newPC       = actual_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid     <= '0;
      missCount <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr[i[IDX_W-1:0]] <= CTR_INIT;
    end else begin
      if (error && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
      if (ex_valid) begin
        if (ex_isBranch) begin
          if (ex_hit) begin
            if (ex_taken && ctr[ex_idx] != 2'b11)       ctr[ex_idx] <= ctr[ex_idx] + 2'd1;
            else if (!ex_taken && ctr[ex_idx] != 2'b00) ctr[ex_idx] <= ctr[ex_idx] - 2'd1;
          end else if (ex_taken) begin
            valid[ex_idx] <= 1'b1;
            ctr[ex_idx]   <= 2'b10;
          end
        end else if (ex_hit) begin
          // A non-branch matching the tag means the entry aliases stale code.
          valid[ex_idx] <= 1'b0;
        end
      end
    end
  end

  // Tags and targets are qualified by valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (rst && ex_valid && ex_isBranch && ex_taken) begin
      target[ex_idx] <= ex_target;
      if (!ex_hit) tag[ex_idx] <= ex_tag;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, ex_pc, ex_target, ex_predPC;
  logic        ex_valid, ex_isBranch, ex_taken;
  logic [15:0] prePC, newPC, missCount;
  logic        predTaken, error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(4), .CTR_INIT(2'b01)) dut (
    .clk(clk), .rst(rst), .pc(pc),
    .ex_valid(ex_valid), .ex_isBranch(ex_isBranch), .ex_taken(ex_taken),
    .ex_pc(ex_pc), .ex_target(ex_target), .ex_predPC(ex_predPC),
    .prePC(prePC), .predTaken(predTaken), .error(error),
    .newPC(newPC), .missCount(missCount)
  );

  typedef struct {
    logic [15:0] pc;
    logic        v, br, tk;
    logic [15:0] epc, tgt, epred;
    logic [15:0] e_pre;
    logic        e_pt, e_err;
    logic [15:0] e_new, e_mc;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic [15:0] pc_i, input logic v, input logic br, input logic tk,
                              input logic [15:0] epc, input logic [15:0] tgt, input logic [15:0] epred,
                              input logic [15:0] e_pre, input logic e_pt, input logic e_err,
                              input logic [15:0] e_new, input logic [15:0] e_mc);
    vec_t r;
    r.pc = pc_i; r.v = v; r.br = br; r.tk = tk; r.epc = epc; r.tgt = tgt; r.epred = epred;
    r.e_pre = e_pre; r.e_pt = e_pt; r.e_err = e_err; r.e_new = e_new; r.e_mc = e_mc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] p, input logic v, input logic br, input logic tk,
                       input logic [15:0] epc, input logic [15:0] tgt, input logic [15:0] epred);
    pc = p; ex_valid = v; ex_isBranch = br; ex_taken = tk;
    ex_pc = epc; ex_target = tgt; ex_predPC = epred;
  endtask

  initial begin
    rst = 1'b0;
    drive(16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

    //          pc        v  br tk ex_pc     target    predPC    prePC     pT err newPC     missCount
    tv.push_back(mk(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 16'h0001, 16'd0));
    tv.push_back(mk(16'h0010, 1, 1, 1, 16'h0010, 16'h0040, 16'h0011, 16'h0011, 0, 1, 16'h0040, 16'd0));
    tv.push_back(mk(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1, 0, 16'h0001, 16'd1));
    tv.push_back(mk(16'h0010, 1, 1, 0, 16'h0010, 16'h0040, 16'h0040, 16'h0040, 1, 1, 16'h0011, 16'd1));
    tv.push_back(mk(16'h0010, 1, 1, 0, 16'h0010, 16'h0040, 16'h0040, 16'h0011, 0, 1, 16'h0011, 16'd2));
    tv.push_back(mk(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 16'h0001, 16'd3));
    tv.push_back(mk(16'h0010, 1, 1, 1, 16'h0010, 16'h0040, 16'h0011, 16'h0011, 0, 1, 16'h0040, 16'd3));
    tv.push_back(mk(16'h0010, 1, 1, 1, 16'h0010, 16'h0040, 16'h0011, 16'h0011, 0, 1, 16'h0040, 16'd4));
    tv.push_back(mk(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0040, 1, 0, 16'h0001, 16'd5));
    tv.push_back(mk(16'h0010, 1, 1, 1, 16'h0110, 16'h0200, 16'h0111, 16'h0040, 1, 1, 16'h0200, 16'd5));
    tv.push_back(mk(16'h0010, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 0, 0, 16'h0001, 16'd6));
    tv.push_back(mk(16'h0110, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 1, 0, 16'h0001, 16'd6));
    tv.push_back(mk(16'h0110, 1, 0, 1, 16'h0110, 16'h0300, 16'h0111, 16'h0200, 1, 0, 16'h0111, 16'd6));
    tv.push_back(mk(16'h0110, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0111, 0, 0, 16'h0001, 16'd6));
    tv.push_back(mk(16'h0110, 0, 1, 1, 16'h0110, 16'h0300, 16'h1234, 16'h0111, 0, 0, 16'h0300, 16'd6));
    tv.push_back(mk(16'h0110, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0111, 0, 0, 16'h0001, 16'd6));
    tv.push_back(mk(16'h0020, 1, 1, 1, 16'h0020, 16'h0050, 16'h0021, 16'h0021, 0, 1, 16'h0050, 16'd6));
    tv.push_back(mk(16'hFFFF, 1, 0, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'd7));
    tv.push_back(mk(16'h0020, 1, 1, 1, 16'h0020, 16'h0050, 16'h0050, 16'h0050, 1, 0, 16'h0050, 16'd7));
    tv.push_back(mk(16'h0020, 1, 1, 1, 16'h0020, 16'h0050, 16'h0050, 16'h0050, 1, 0, 16'h0050, 16'd7));
    tv.push_back(mk(16'h0020, 1, 1, 0, 16'h0020, 16'h0050, 16'h0050, 16'h0050, 1, 1, 16'h0021, 16'd7));
    tv.push_back(mk(16'h0020, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0050, 1, 0, 16'h0001, 16'd8));

    repeat (2) @(negedge clk);
    #1;
    chk("reset_missCount", missCount, 16'd0);
    chk("reset_predTaken", {15'd0, predTaken}, 16'd0);
    rst = 1'b1;

    foreach (tv[i]) begin
      @(negedge clk);
      drive(tv[i].pc, tv[i].v, tv[i].br, tv[i].tk, tv[i].epc, tv[i].tgt, tv[i].epred);
      #1;
      chk($sformatf("v%0d_prePC", i), prePC, tv[i].e_pre);
      chk($sformatf("v%0d_predTaken", i), {15'd0, predTaken}, {15'd0, tv[i].e_pt});
      chk($sformatf("v%0d_error", i), {15'd0, error}, {15'd0, tv[i].e_err});
      chk($sformatf("v%0d_newPC", i), newPC, tv[i].e_new);
      chk($sformatf("v%0d_missCount", i), missCount, tv[i].e_mc);
    end

    // Non-branch at idx 0 with a tag that misses: every edge mispredicts, table untouched.
    @(negedge clk);
    drive(16'h0020, 1, 0, 0, 16'h0100, 16'h0000, 16'h0000);
    repeat (65540) @(negedge clk);
    #1;
    chk("sat_missCount", missCount, 16'hFFFF);
    chk("sat_error", {15'd0, error}, 16'd1);
    chk("sat_entry_kept", prePC, 16'h0050);

    // Reset mid-cycle while a taken branch is being resolved.
    @(negedge clk);
    drive(16'h0020, 1, 1, 1, 16'h0030, 16'h0070, 16'h0031);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_missCount", missCount, 16'd0);
    chk("rst_predTaken", {15'd0, predTaken}, 16'd0);
    chk("rst_prePC", prePC, 16'h0021);
    chk("rst_error_comb", {15'd0, error}, 16'd1);
    chk("rst_newPC_comb", newPC, 16'h0070);
    @(negedge clk);
    rst = 1'b1;
    drive(16'h0030, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
    #1;
    chk("post_rst_0030_miss", prePC, 16'h0031);
    chk("post_rst_0030_pt", {15'd0, predTaken}, 16'd0);
    chk("post_rst_missCount", missCount, 16'd0);
    @(negedge clk);
    pc = 16'h0020;
    #1;
    chk("post_rst_0020_miss", prePC, 16'h0021);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
